// File: rtl/serdesphy_prbs_checker.sv
// -----------------------------------------------------------------------------
// serdesphy_prbs_checker
//
// Receive-side PRBS7 (x^7 + x^6 + 1) checker for the 4-bit deserialised
// nibble stream. The checker seeds its LFSR from the incoming data, confirms
// the seed over LOCK_CNT clean nibbles, and then declares lock. While locked
// it free-runs the LFSR and counts bit errors. Too many errored nibbles in a
// row drop lock and force a re-seed.
//
// Optional feature (compile-time macro SERDESPHY_PRBS_POLARITY_EN):
//   adds rx_invert (bitwise inversion of rx_data before use) and
//   prbs_inv_det, which is set when the line appears to carry an inverted
//   PRBS7 stream.
//
// Ports:
//   clk          in   datapath clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   checker enable; 0 sends the FSM to IDLE on the next edge
//   rx_data[3:0] in   received nibble; bit 3 is the first bit on the line
//   rx_valid     in   rx_data qualifier; all state holds when low
//   err_clr      in   synchronous clear of err_count (wins over an increment)
//   rx_invert    in   [polarity build only] invert rx_data before use
//   prbs_inv_det out  [polarity build only] inverted stream detected
//   prbs_lock    out  checker locked to the PRBS7 stream
//   prbs_err     out  1-cycle pulse: last valid nibble had a bit error while locked
//   err_count    out  saturating count of bit errors seen while locked
//
// Handshake: a nibble is consumed on every rising clk edge where
// rx_valid=1; there is no backpressure. With rx_valid=0 nothing advances
// and prbs_err is 0. The enable input is a control, not data: enable=0
// forces IDLE and enable=1 leaves IDLE on the next edge regardless of
// rx_valid.
//
// Debug: the FSM state is held in state_q (type state_t) so checkers can
// bind to it directly.
// -----------------------------------------------------------------------------
module serdesphy_prbs_checker #(
  parameter int LOCK_CNT   = 8,   // 1..255
  parameter int UNLOCK_CNT = 4,   // 1..15
  parameter int CNT_W      = 16   // >= 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [3:0]       rx_data,
  input  logic             rx_valid,
  input  logic             err_clr,
`ifdef SERDESPHY_PRBS_POLARITY_EN
  input  logic             rx_invert,
  output logic             prbs_inv_det,
`endif
  output logic             prbs_lock,
  output logic             prbs_err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam logic [7:0] LOCK_CNT_L   = 8'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_CNT_L = 4'(UNLOCK_CNT);

  state_t     state_q;
  logic [6:0] lfsr_q;
  logic       seed_cnt_q;   // 0: expecting first seed nibble, 1: second
  logic [7:0] good_cnt_q;
  logic [3:0] bad_cnt_q;
`ifdef SERDESPHY_PRBS_POLARITY_EN
  logic [7:0] inv_cnt_q;    // consecutive fully-inverted CHECK nibbles
`endif

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [3:0]       data_eff;
  logic [3:0]       pred_nib;
  logic [6:0]       lfsr_adv;
  logic [6:0]       seed_next;
  logic [3:0]       err_vec;
  logic [2:0]       nerr;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_sat;
  logic [7:0]       good_inc;
  logic [3:0]       bad_inc;
  logic             nib_ok;
  logic             count_err;

`ifdef SERDESPHY_PRBS_POLARITY_EN
  logic [7:0] inv_inc;
  assign data_eff = rx_data ^ {4{rx_invert}};
  assign inv_inc  = inv_cnt_q + 8'd1;
`else
  assign data_eff = rx_data;
`endif

  // Four LFSR steps; the first generated bit is the one compared with bit 3.
  function automatic logic [10:0] step4(input logic [6:0] s_in);
    logic [6:0] s;
    logic [3:0] p;
    logic       b;
    s = s_in;
    p = '0;
    for (int i = 3; i >= 0; i--) begin
      b    = s[6] ^ s[5];
      p[i] = b;
      s    = {s[5:0], b};
    end
    return {p, s};
  endfunction

  assign {pred_nib, lfsr_adv} = step4(lfsr_q);

  // Seeding shifts the nibble in line order (bit 3 oldest), so after two
  // nibbles s[0] is the newest bit and s[6] the oldest of the last seven.
  assign seed_next = {lfsr_q[2:0], data_eff};

  assign err_vec  = pred_nib ^ data_eff;
  assign nerr     = {2'b00, err_vec[3]} + {2'b00, err_vec[2]}
                  + {2'b00, err_vec[1]} + {2'b00, err_vec[0]};
  assign nib_ok   = (err_vec == 4'h0);
  assign good_inc = good_cnt_q + 8'd1;
  assign bad_inc  = bad_cnt_q + 4'd1;

  // Saturating accumulate: the extra top bit catches the carry out.
  assign cnt_sum = {1'b0, err_count} + (CNT_W+1)'(nerr);
  assign cnt_sat = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  assign count_err = enable && rx_valid && (state_q == ST_LOCKED) && !nib_ok;

  // ---------------------------------------------------------------------------
  // Error counter (independent of FSM transitions; clear has priority)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (count_err) begin
      err_count <= cnt_sat;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= 7'h00;
      seed_cnt_q   <= 1'b0;
      good_cnt_q   <= 8'd0;
      bad_cnt_q    <= 4'd0;
      prbs_lock    <= 1'b0;
      prbs_err     <= 1'b0;
`ifdef SERDESPHY_PRBS_POLARITY_EN
      inv_cnt_q    <= 8'd0;
      prbs_inv_det <= 1'b0;
`endif
    end else begin
      prbs_err <= 1'b0;
      if (!enable) begin
        state_q      <= ST_IDLE;
        seed_cnt_q   <= 1'b0;
        good_cnt_q   <= 8'd0;
        bad_cnt_q    <= 4'd0;
        prbs_lock    <= 1'b0;
`ifdef SERDESPHY_PRBS_POLARITY_EN
        inv_cnt_q    <= 8'd0;
        prbs_inv_det <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q    <= ST_SEED;
            seed_cnt_q <= 1'b0;
          end

          ST_SEED: begin
            if (rx_valid) begin
              lfsr_q <= seed_next;
              if (seed_cnt_q) begin
                // All-zero is the LFSR's dead state; keep seeding instead.
                seed_cnt_q <= 1'b0;
                if (seed_next != 7'h00) begin
                  state_q    <= ST_CHECK;
                  good_cnt_q <= 8'd0;
                end
              end else begin
                seed_cnt_q <= 1'b1;
              end
            end
          end

          ST_CHECK: begin
            if (rx_valid) begin
              if (nib_ok) begin
                lfsr_q <= lfsr_adv;
                if (good_inc == LOCK_CNT_L) begin
                  state_q      <= ST_LOCKED;
                  prbs_lock    <= 1'b1;
                  bad_cnt_q    <= 4'd0;
`ifdef SERDESPHY_PRBS_POLARITY_EN
                  prbs_inv_det <= 1'b0;
`endif
                end else begin
                  good_cnt_q <= good_inc;
                end
              end else begin
                // Bad seed: re-seed silently, nothing is counted here.
                state_q    <= ST_SEED;
                seed_cnt_q <= 1'b0;
              end
`ifdef SERDESPHY_PRBS_POLARITY_EN
              // The inversion tally survives the SEED detours that every
              // inverted nibble causes; only non-inverted CHECK data resets it.
              if (err_vec == 4'hF) begin
                if (inv_inc == LOCK_CNT_L) begin
                  prbs_inv_det <= 1'b1;
                  inv_cnt_q    <= 8'd0;
                end else begin
                  inv_cnt_q <= inv_inc;
                end
              end else begin
                inv_cnt_q <= 8'd0;
              end
              if (nib_ok && good_inc == LOCK_CNT_L) begin
                inv_cnt_q <= 8'd0;
              end
`endif
            end
          end

          ST_LOCKED: begin
            if (rx_valid) begin
              // Locked LFSR is never reloaded from data; errors stay local.
              lfsr_q <= lfsr_adv;
              if (!nib_ok) begin
                prbs_err <= 1'b1;
                if (bad_inc == UNLOCK_CNT_L) begin
                  state_q    <= ST_SEED;
                  prbs_lock  <= 1'b0;
                  bad_cnt_q  <= 4'd0;
                  seed_cnt_q <= 1'b0;
                end else begin
                  bad_cnt_q <= bad_inc;
                end
              end else begin
                bad_cnt_q <= 4'd0;
              end
            end
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serdesphy_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_serdesphy_prbs_checker
//
// Directed sequence with randomised error masks, gap lengths and filler data.
// The reference is a PRBS7 bit-recurrence source (b[t] = b[t-7] ^ b[t-6],
// history starting all ones) plus expectations derived from the lock /
// unlock / counting rules: lock after 2 seed + LOCK_CNT check nibbles,
// unlock after UNLOCK_CNT errored nibbles, err_count = saturating sum of
// error bits while locked.
// -----------------------------------------------------------------------------
module tb_serdesphy_prbs_checker;

  localparam int LOCK   = 8;
  localparam int UNLOCK = 4;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [3:0]    rx_data = 4'h0;
  logic          rx_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic          prbs_lock;
  logic          prbs_err;
  logic [CW-1:0] err_count;
`ifdef SERDESPHY_PRBS_POLARITY_EN
  logic          rx_invert = 1'b0;
  logic          prbs_inv_det;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  // Last seven line bits of the reference source, oldest first.
  bit gq[$];

  serdesphy_prbs_checker #(
    .LOCK_CNT  (LOCK),
    .UNLOCK_CNT(UNLOCK),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .err_clr     (err_clr),
`ifdef SERDESPHY_PRBS_POLARITY_EN
    .rx_invert   (rx_invert),
    .prbs_inv_det(prbs_inv_det),
`endif
    .prbs_lock   (prbs_lock),
    .prbs_err    (prbs_err),
    .err_count   (err_count)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- reference source ----
  function automatic logic [3:0] gen_nib();
    logic [3:0] n;
    bit         b;
    n = '0;
    for (int i = 3; i >= 0; i--) begin
      b = gq[0] ^ gq[1];
      void'(gq.pop_front());
      gq.push_back(b);
      n[i] = b;
    end
    return n;
  endfunction

  // True when any of the next four reference nibbles is 4'hF.
  function automatic bit next4_has_f();
    bit         q[$];
    bit         b;
    logic [3:0] n;
    bit         hit;
    q   = gq;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = '0;
      for (int i = 3; i >= 0; i--) begin
        b = q[0] ^ q[1];
        void'(q.pop_front());
        q.push_back(b);
        n[i] = b;
      end
      if (n == 4'hF) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // ---- checking ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- driver ----
  task automatic send(input logic [3:0] d, input logic v);
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    enable = 1'b0;
    send(4'h0, 1'b0);
    chk("restart_idle_lock", {31'd0, prbs_lock}, 32'd0);
    enable = 1'b1;
    send(4'h0, 1'b0);
  endtask

  initial begin
    logic [3:0] n;
    logic [3:0] m;
    int         gap;

    for (int i = 0; i < 7; i++) gq.push_back(1'b1);

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lock", {31'd0, prbs_lock}, 32'd0);
    chk("rst_err",  {31'd0, prbs_err},  32'd0);
    chk("rst_cnt",  32'(err_count),     32'd0);
    rst_n = 1'b1;
    send(4'h0, 1'b0);
    chk("idle_lock", {31'd0, prbs_lock}, 32'd0);

    // ---- 1: clean stream, lock point and long error-free run ----
    enable = 1'b1;
    send(4'h0, 1'b0);
    for (int i = 1; i <= 2 + LOCK; i++) begin
      send(gen_nib(), 1'b1);
      chk("t1_lock", {31'd0, prbs_lock}, (i == 2 + LOCK) ? 32'd1 : 32'd0);
      chk("t1_err",  {31'd0, prbs_err},  32'd0);
    end
    for (int i = 0; i < 1000; i++) begin
      send(gen_nib(), 1'b1);
      chk("t1_run_lock", {31'd0, prbs_lock}, 32'd1);
      chk("t1_run_err",  {31'd0, prbs_err},  32'd0);
    end
    chk("t1_cnt", 32'(err_count), 32'd0);

    // ---- 2: single errored nibbles ----
    n = gen_nib();
    send(n ^ 4'b1001, 1'b1);
    exp_cnt = 2;
    chk("t2_err_pulse", {31'd0, prbs_err},  32'd1);
    chk("t2_lock",      {31'd0, prbs_lock}, 32'd1);
    send(gen_nib(), 1'b1);
    chk("t2_err_end",   {31'd0, prbs_err},  32'd0);
    chk("t2_cnt",       32'(err_count),     32'(exp_cnt));
    for (int k = 0; k < 3; k++) begin
      gap = $urandom_range(1, 5);
      for (int j = 0; j < gap; j++) send(gen_nib(), 1'b1);
      m = 4'($urandom_range(1, 15));
      send(gen_nib() ^ m, 1'b1);
      exp_cnt = sat(exp_cnt + $countones(m));
      chk("t2r_err_pulse", {31'd0, prbs_err},  32'd1);
      chk("t2r_lock",      {31'd0, prbs_lock}, 32'd1);
      send(gen_nib(), 1'b1);
      chk("t2r_err_end",   {31'd0, prbs_err},  32'd0);
      chk("t2r_cnt",       32'(err_count),     32'(exp_cnt));
    end
    err_clr = 1'b1;
    send(gen_nib(), 1'b1);
    err_clr = 1'b0;
    exp_cnt = 0;
    chk("t2_clr", 32'(err_count), 32'd0);
    // Clear coinciding with an errored nibble: clear wins, pulse still fires.
    m = 4'($urandom_range(1, 15));
    err_clr = 1'b1;
    send(gen_nib() ^ m, 1'b1);
    err_clr = 1'b0;
    chk("t2_clr_err_pulse", {31'd0, prbs_err}, 32'd1);
    chk("t2_clr_wins",      32'(err_count),    32'd0);
    send(gen_nib(), 1'b1);
    chk("t2_clr_after",     32'(err_count),    32'd0);

    // ---- 3: burst of 4'hF nibbles forces unlock, then relock ----
    for (int g = 0; g < 200 && next4_has_f(); g++) send(gen_nib(), 1'b1);
    for (int i = 1; i <= UNLOCK; i++) begin
      n = gen_nib();
      send(4'hF, 1'b1);
      exp_cnt = sat(exp_cnt + $countones(n ^ 4'hF));
      chk("t3_err_pulse", {31'd0, prbs_err},  32'd1);
      chk("t3_lock",      {31'd0, prbs_lock}, (i < UNLOCK) ? 32'd1 : 32'd0);
    end
    chk("t3_cnt", 32'(err_count), 32'(exp_cnt));
    for (int i = 1; i <= 2 + LOCK; i++) begin
      send(gen_nib(), 1'b1);
      chk("t3_relock", {31'd0, prbs_lock}, (i == 2 + LOCK) ? 32'd1 : 32'd0);
      chk("t3_no_err", {31'd0, prbs_err},  32'd0);
    end
    chk("t3_cnt_hold", 32'(err_count), 32'(exp_cnt));

    // ---- 4: all-zero input keeps seeding, then a real stream locks ----
    err_clr = 1'b1;
    restart();
    err_clr = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      send(4'h0, 1'b1);
      chk("t4_zero_lock", {31'd0, prbs_lock}, 32'd0);
      chk("t4_zero_err",  {31'd0, prbs_err},  32'd0);
    end
    chk("t4_cnt", 32'(err_count), 32'd0);
    for (int i = 1; i <= 2 + LOCK; i++) begin
      send(gen_nib(), 1'b1);
      chk("t4_lock", {31'd0, prbs_lock}, (i == 2 + LOCK) ? 32'd1 : 32'd0);
    end

    // ---- 5: gapped rx_valid, then saturation ----
    restart();
    for (int i = 1; i <= 2 + LOCK; i++) begin
      send(gen_nib(), 1'b1);
      chk("t5_lock", {31'd0, prbs_lock}, (i == 2 + LOCK) ? 32'd1 : 32'd0);
      send(4'($urandom_range(0, 15)), 1'b0);
      chk("t5_gap_lock", {31'd0, prbs_lock}, (i == 2 + LOCK) ? 32'd1 : 32'd0);
      chk("t5_gap_err",  {31'd0, prbs_err},  32'd0);
    end
    for (int i = 0; i < 100; i++) begin
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) send(4'($urandom_range(0, 15)), 1'b0);
      send(gen_nib(), 1'b1);
      chk("t5_run_err",  {31'd0, prbs_err},  32'd0);
      chk("t5_run_lock", {31'd0, prbs_lock}, 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      m = 4'($urandom_range(0, 15)) | 4'b0011;
      send(gen_nib() ^ m, 1'b1);
      exp_cnt = sat(exp_cnt + $countones(m));
      chk("t5_sat_pulse", {31'd0, prbs_err}, 32'd1);
      chk("t5_sat_cnt",   32'(err_count),    32'(exp_cnt));
      send(gen_nib(), 1'b1);
    end
    chk("t5_saturated", 32'(err_count), 32'(CMAX));
    chk("t5_sat_lock",  {31'd0, prbs_lock}, 32'd1);
    err_clr = 1'b1;
    send(gen_nib(), 1'b1);
    err_clr = 1'b0;
    exp_cnt = 0;
    chk("t5_clr", 32'(err_count), 32'd0);

    // ---- mid-operation asynchronous reset ----
    m = 4'($urandom_range(1, 15));
    send(gen_nib() ^ m, 1'b1);
    chk("rst2_pre_cnt", 32'(err_count), 32'($countones(m)));
    rst_n = 1'b0;
    #1;
    chk("rst2_lock", {31'd0, prbs_lock}, 32'd0);
    chk("rst2_err",  {31'd0, prbs_err},  32'd0);
    chk("rst2_cnt",  32'(err_count),     32'd0);
    send(4'h0, 1'b0);
    rst_n = 1'b1;
    send(4'h0, 1'b0);
    chk("rst2_after_cnt", 32'(err_count), 32'd0);

`ifdef SERDESPHY_PRBS_POLARITY_EN
    // ---- 6: inverted stream detection and correction ----
    restart();
    rx_invert = 1'b0;
    for (int i = 0; i < 60; i++) begin
      send(~gen_nib(), 1'b1);
      chk("t6_inv_nolock", {31'd0, prbs_lock}, 32'd0);
    end
    chk("t6_inv_det", {31'd0, prbs_inv_det}, 32'd1);
    rx_invert = 1'b1;
    restart();
    chk("t6_inv_det_idle", {31'd0, prbs_inv_det}, 32'd0);
    for (int i = 1; i <= 2 + LOCK; i++) begin
      send(~gen_nib(), 1'b1);
      chk("t6_lock",    {31'd0, prbs_lock},    (i == 2 + LOCK) ? 32'd1 : 32'd0);
      chk("t6_inv_clr", {31'd0, prbs_inv_det}, 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
